// File: rtl/booth_sat_fixmul.sv
// Iterative radix-2 Booth signed multiplier with a Q(WHOLE).(FRAC) truncating,
// saturating output stage. One Booth step per clock, arm/fin request handshake.
module booth_sat_fixmul #(
    parameter int A1_LEN    = 64,
    parameter int A2_LEN    = 64,
    parameter int A2LEN_SIZ = 7,
    parameter int WHOLE     = 21,
    parameter int FRAC      = 43
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       arm,
    input  logic [A1_LEN-1:0]          a1,
    input  logic [A2_LEN-1:0]          a2,
    output logic                       fin,
    output logic [A1_LEN+A2_LEN-1:0]   outn,
    output logic [A1_LEN-1:0]          out_sat
);
    localparam int PW = A1_LEN + A2_LEN;
    localparam int TW = PW - FRAC;

    // Handshake: arm is a level request held until fin is seen; fin stays high
    // while arm stays high and drops on the first edge that sees arm low.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state;

    logic [A1_LEN-1:0]    mcand;
    logic [A1_LEN:0]      acc_hi;   // one guard bit so subtracting -2^(A1_LEN-1) cannot overflow
    logic [A2_LEN-1:0]    q;
    logic                 q_m1;
    logic [A2LEN_SIZ-1:0] cnt;

    logic [A1_LEN:0] mcand_ext;
    logic [A1_LEN:0] sum;

    assign mcand_ext = {mcand[A1_LEN-1], mcand};

    always_comb begin
        sum = acc_hi;
        case ({q[0], q_m1})
            2'b01:   sum = acc_hi + mcand_ext;
            2'b10:   sum = acc_hi - mcand_ext;
            default: sum = acc_hi;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            fin    <= 1'b0;
            outn   <= '0;
            mcand  <= '0;
            acc_hi <= '0;
            q      <= '0;
            q_m1   <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    fin <= 1'b0;
                    if (arm) begin
                        mcand  <= a1;
                        q      <= a2;
                        q_m1   <= 1'b0;
                        acc_hi <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (!arm) begin
                        state <= IDLE;
                    end else if (cnt == A2LEN_SIZ'(A2_LEN)) begin
                        // The product always fits PW bits, so the guard bit is dropped.
                        outn  <= {acc_hi[A1_LEN-1:0], q};
                        fin   <= 1'b1;
                        state <= DONE;
                    end else begin
                        acc_hi <= {sum[A1_LEN], sum[A1_LEN:1]};
                        q      <= {sum[0], q[A2_LEN-1:1]};
                        q_m1   <= q[0];
                        cnt    <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (!arm) begin
                        fin   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    fin   <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Dropping the low FRAC bits of outn is an arithmetic shift right with
    // truncation toward -inf; the result fits when the top WHOLE+1 bits agree.
    logic [TW-1:0]    t;
    logic [WHOLE:0]   t_top;
    logic             t_fits;

    assign t      = outn[PW-1:FRAC];
    assign t_top  = t[TW-1 -: WHOLE+1];
    assign t_fits = (&t_top) | ~(|t_top);

    always_comb begin
        if (t_fits)
            out_sat = t[A1_LEN-1:0];
        else if (t[TW-1])
            out_sat = {1'b1, {(A1_LEN-1){1'b0}}};
        else
            out_sat = {1'b0, {(A1_LEN-1){1'b1}}};
    end

endmodule

// File: tb/tb_booth_sat_fixmul.sv
// Directed and random checks of booth_sat_fixmul against a plain-arithmetic
// model of the signed product and Q21.43 saturation.
module tb_booth_sat_fixmul;
    logic         clk;
    logic         rst;
    logic         arm;
    logic [63:0]  a1;
    logic [63:0]  a2;
    logic         fin;
    logic [127:0] outn;
    logic [63:0]  out_sat;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0]  exp_q[$];
    logic [127:0] last_prod;

    booth_sat_fixmul dut (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .a1      (a1),
        .a2      (a2),
        .fin     (fin),
        .outn    (outn),
        .out_sat (out_sat)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model
    function automatic logic [127:0] ref_prod(input logic [63:0] x, input logic [63:0] y);
        logic signed [127:0] xs, ys;
        xs = {{64{x[63]}}, x};
        ys = {{64{y[63]}}, y};
        return xs * ys;
    endfunction

    function automatic logic [63:0] ref_sat(input logic [127:0] p);
        logic signed [127:0] t, hi, lo;
        t  = $signed(p) >>> 43;
        hi = {64'd0, 64'h7FFF_FFFF_FFFF_FFFF};
        lo = {{64{1'b1}}, 64'h8000_0000_0000_0000};
        if (t > hi)      return 64'h7FFF_FFFF_FFFF_FFFF;
        else if (t < lo) return 64'h8000_0000_0000_0000;
        else             return t[63:0];
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arm with x*y, scramble the operands after the arming edge, wait for fin,
    // check latency and results, then release arm and check fin drops.
    task automatic do_mul(input logic [63:0] x, input logic [63:0] y, input string tag);
        int edges;
        logic [63:0] exp_sat;
        a1  = x;
        a2  = y;
        arm = 1'b1;
        tick();
        a1 = {$urandom, $urandom};
        a2 = {$urandom, $urandom};
        last_prod = ref_prod(x, y);
        exp_q.push_back(ref_sat(last_prod));
        edges = 0;
        while (!fin && edges < 200) begin
            tick();
            edges++;
        end
        chk({tag, "_latency"}, 128'(edges), 128'd65);
        chk({tag, "_outn"}, outn, last_prod);
        exp_sat = exp_q.pop_front();
        chk({tag, "_out_sat"}, {64'd0, out_sat}, {64'd0, exp_sat});
    endtask

    task automatic release_arm(input string tag);
        arm = 1'b0;
        tick();
        chk({tag, "_fin_drop"}, {127'd0, fin}, 128'd0);
    endtask

    initial begin
        int fin_seen;
        logic [63:0] x, y;

        rst = 1'b1;
        arm = 1'b0;
        a1  = '0;
        a2  = '0;
        #23;
        chk("reset_fin", {127'd0, fin}, 128'd0);
        chk("reset_outn", outn, 128'd0);
        chk("reset_out_sat", {64'd0, out_sat}, 128'd0);
        rst = 1'b0;
        tick();

        // basic 1.5 * 2.0
        do_mul(64'h0000_0C00_0000_0000, 64'h0000_1000_0000_0000, "basic");
        chk("basic_const_sat", {64'd0, out_sat}, {64'd0, 64'h0000_1800_0000_0000});
        chk("basic_const_outn", outn, 128'd3 << 86);

        // hold arm 10 edges past fin
        repeat (10) tick();
        chk("hold_fin", {127'd0, fin}, 128'd1);
        chk("hold_outn", outn, 128'd3 << 86);
        release_arm("basic");

        do_mul(64'hFFFF_F800_0000_0000, 64'h0000_0800_0000_0000, "neg_one");
        chk("neg_one_const", {64'd0, out_sat}, {64'd0, 64'hFFFF_F800_0000_0000});
        release_arm("neg_one");

        do_mul(64'hFFFF_EC00_0000_0000, 64'hFFFF_E000_0000_0000, "neg_neg");
        chk("neg_neg_const", {64'd0, out_sat}, {64'd0, 64'h0000_5000_0000_0000});
        release_arm("neg_neg");

        do_mul(64'h4000_0000_0000_0000, 64'h0000_2000_0000_0000, "sat_pos");
        chk("sat_pos_const", {64'd0, out_sat}, {64'd0, 64'h7FFF_FFFF_FFFF_FFFF});
        release_arm("sat_pos");

        do_mul(64'hC000_0000_0000_0000, 64'h0000_2000_0000_0000, "sat_neg");
        chk("sat_neg_const", {64'd0, out_sat}, {64'd0, 64'h8000_0000_0000_0000});
        release_arm("sat_neg");

        do_mul(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, "min_min");
        chk("min_min_outn", outn, 128'd1 << 126);
        chk("min_min_const", {64'd0, out_sat}, {64'd0, 64'h7FFF_FFFF_FFFF_FFFF});
        release_arm("min_min");

        do_mul(64'd1, 64'h0000_0400_0000_0000, "trunc_pos");
        chk("trunc_pos_const", {64'd0, out_sat}, 128'd0);
        release_arm("trunc_pos");

        // re-arm on the very next edge after release
        do_mul(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0400_0000_0000, "trunc_neg");
        chk("trunc_neg_const", {64'd0, out_sat}, {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
        release_arm("trunc_neg");

        // random operands, magnitudes spread by an arithmetic shift
        for (int i = 0; i < 8; i++) begin
            x = {$urandom, $urandom};
            y = {$urandom, $urandom};
            x = $signed(x) >>> $urandom_range(0, 40);
            y = $signed(y) >>> $urandom_range(0, 40);
            do_mul(x, y, $sformatf("rand%0d", i));
            release_arm($sformatf("rand%0d", i));
        end

        // abort: arm dropped on edge 30 after arming
        a1  = 64'h0000_0C00_0000_0000;
        a2  = 64'h1234_5678_9ABC_DEF0;
        arm = 1'b1;
        tick();
        repeat (29) tick();
        arm = 1'b0;
        fin_seen = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (fin) fin_seen++;
        end
        chk("abort_fin_never", 128'(fin_seen), 128'd0);
        chk("abort_outn_kept", outn, last_prod);

        // asynchronous reset mid-BUSY
        a1  = 64'h0000_0C00_0000_0000;
        a2  = 64'h0000_1000_0000_0000;
        arm = 1'b1;
        tick();
        repeat (20) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_fin", {127'd0, fin}, 128'd0);
        chk("arst_outn", outn, 128'd0);
        chk("arst_out_sat", {64'd0, out_sat}, 128'd0);
        arm = 1'b0;
        #3;
        rst = 1'b0;
        tick();

        do_mul(64'hFFFF_EC00_0000_0000, 64'h0000_1000_0000_0000, "post_rst");
        release_arm("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // overall time guard
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
